dpll_loop_ctrl: RTL

//  Parametrised digital PLL loop core: measures ref/feedback phase error in clk cycles, runs a PI loop

---
 rtl/dpll_loop_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dpll_loop_ctrl.sv
// -----------------------------------------------------------------------------
// dpll_loop_ctrl
//   Digital PLL loop core. Measures the phase error between the reference
//   clock and the divided feedback clock in units of clk cycles, filters it
//   through a saturating PI loop filter to produce a signed DCO control word,
//   and reports lock with separate good/bad sample counts for hysteresis.
//
// Ports
//   clk        in   1       sampling clock, all logic on posedge
//   rst        in   1       asynchronous active-high reset
//   ref_in     in   1       reference clock (asynchronous to clk)
//   fb_in      in   1       divided feedback clock (asynchronous to clk)
//   hold       in   1       holdover: freeze integrator and ctrl
//   phase_err  out  ERR_W   last signed phase error (+ = ref leads)
//   err_valid  out  1       one-cycle pulse when phase_err updates
//   ctrl       out  CTRL_W  signed DCO control word
//   ctrl_valid out  1       one-cycle pulse when ctrl updates
//   locked     out  1       lock indicator
// -----------------------------------------------------------------------------
module dpll_loop_ctrl #(
  parameter int CTRL_W     = 16,
  parameter int ERR_W      = 12,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 6,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CTRL_INIT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_in,
  input  logic              fb_in,
  input  logic              hold,
  output logic [ERR_W-1:0]  phase_err,
  output logic              err_valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              locked
);

  // Cycle counter width: its all-ones value is exactly ERR_MAX.
  localparam int CW = ERR_W - 1;
  localparam int IW = CTRL_W + KI_SHIFT;
  localparam int PW = ERR_W + KP_SHIFT;
  localparam int SW = ((CTRL_W > PW) ? CTRL_W : PW) + 2;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0]            ERR_MAX_C = '1;
  localparam logic signed [IW-1:0]     INTEG_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0]     INTEG_MIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic signed [SW-1:0]     CMAX_S    = SW'({1'b0, {(CTRL_W-1){1'b1}}});
  localparam logic signed [SW-1:0]     CMIN_S    = ~CMAX_S;
  localparam logic signed [CTRL_W-1:0] INIT_C    = CTRL_W'(CTRL_INIT);

  // ---------------------------------------------------------------------------
  // Input synchronisers and rising-edge detect
  // ---------------------------------------------------------------------------
  logic ref_s1_q, ref_s2_q, ref_s3_q;
  logic fb_s1_q, fb_s2_q, fb_s3_q;
  logic ref_rise, fb_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_s3_q <= 1'b0;
      fb_s1_q  <= 1'b0;
      fb_s2_q  <= 1'b0;
      fb_s3_q  <= 1'b0;
    end else begin
      ref_s1_q <= ref_in;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
      fb_s1_q  <= fb_in;
      fb_s2_q  <= fb_s1_q;
      fb_s3_q  <= fb_s2_q;
    end
  end

  assign ref_rise = ref_s2_q & ~ref_s3_q;
  assign fb_rise  = fb_s2_q & ~fb_s3_q;

  // ---------------------------------------------------------------------------
  // Phase detector FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    LEAD_REF,
    LEAD_FB
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           emit_d, emit_neg, emit_slip_d;
  logic [CW-1:0]  emit_mag;
  logic [ERR_W-1:0] emit_mag_ext, emit_err_d;

  assign cnt_inc = (cnt_q == ERR_MAX_C) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ref_rise && !fb_rise) begin
          state_d = LEAD_REF;
          cnt_d   = CW'(1);
        end else if (fb_rise && !ref_rise) begin
          state_d = LEAD_FB;
          cnt_d   = CW'(1);
        end
      end
      LEAD_REF: begin
        if (fb_rise) begin
          // A coincident ref edge starts the next measurement immediately.
          state_d = ref_rise ? LEAD_REF : IDLE;
          cnt_d   = ref_rise ? CW'(1) : '0;
        end else if (ref_rise) begin
          cnt_d = CW'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LEAD_FB: begin
        if (ref_rise) begin
          state_d = fb_rise ? LEAD_FB : IDLE;
          cnt_d   = fb_rise ? CW'(1) : '0;
        end else if (fb_rise) begin
          cnt_d = CW'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    emit_d      = 1'b0;
    emit_neg    = 1'b0;
    emit_slip_d = 1'b0;
    emit_mag    = '0;
    case (state_q)
      IDLE: begin
        emit_d = ref_rise & fb_rise;
      end
      LEAD_REF: begin
        if (fb_rise) begin
          emit_d   = 1'b1;
          emit_mag = cnt_q;
        end else if (ref_rise) begin
          emit_d      = 1'b1;
          emit_slip_d = 1'b1;
          emit_mag    = ERR_MAX_C;
        end
      end
      LEAD_FB: begin
        emit_neg = 1'b1;
        if (ref_rise) begin
          emit_d   = 1'b1;
          emit_mag = cnt_q;
        end else if (fb_rise) begin
          emit_d      = 1'b1;
          emit_slip_d = 1'b1;
          emit_mag    = ERR_MAX_C;
        end
      end
      default: ;
    endcase
  end

  assign emit_mag_ext = {1'b0, emit_mag};
  assign emit_err_d   = emit_neg ? ('0 - emit_mag_ext) : emit_mag_ext;

  logic [ERR_W-1:0] phase_err_q;
  logic             err_valid_q, err_slip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      err_slip_q  <= 1'b0;
    end else begin
      err_valid_q <= emit_d;
      if (emit_d) begin
        phase_err_q <= emit_err_d;
        err_slip_q  <= emit_slip_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PI loop filter
  // ---------------------------------------------------------------------------
  logic signed [IW-1:0]     integ_q, integ_d, integ_new;
  logic signed [IW:0]       integ_sum, err_ext_i;
  logic signed [SW-1:0]     p_term, i_term, init_term, ctrl_sum;
  logic signed [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_sat;
  logic                     ctrl_valid_q, update;

  assign update    = err_valid_q & ~hold;
  assign err_ext_i = (IW+1)'($signed(phase_err_q));
  assign integ_sum = (IW+1)'(integ_q) + err_ext_i;

  always_comb begin
    if (integ_sum[IW] != integ_sum[IW-1]) begin
      integ_new = integ_sum[IW] ? INTEG_MIN : INTEG_MAX;
    end else begin
      integ_new = integ_sum[IW-1:0];
    end
  end

  // Integral term has only CTRL_W significant bits after the shift, so the
  // size cast to SW never loses information.
  assign p_term    = SW'($signed(phase_err_q)) <<< KP_SHIFT;
  assign i_term    = SW'(integ_new >>> KI_SHIFT);
  assign init_term = SW'(INIT_C);
  assign ctrl_sum  = init_term + p_term + i_term;

  always_comb begin
    if (ctrl_sum > CMAX_S) begin
      ctrl_sat = CMAX_S[CTRL_W-1:0];
    end else if (ctrl_sum < CMIN_S) begin
      ctrl_sat = CMIN_S[CTRL_W-1:0];
    end else begin
      ctrl_sat = ctrl_sum[CTRL_W-1:0];
    end
  end

  assign integ_d = update ? integ_new : integ_q;
  assign ctrl_d  = update ? ctrl_sat : ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q      <= '0;
      ctrl_q       <= INIT_C;
      ctrl_valid_q <= 1'b0;
    end else begin
      integ_q      <= integ_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= update;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock detector (runs on every error sample, regardless of hold)
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_abs;
  logic             good_s;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [BW-1:0]    bad_cnt_q, bad_cnt_d;
  logic             locked_q, locked_d;

  assign err_abs = phase_err_q[ERR_W-1] ? ('0 - phase_err_q) : phase_err_q;
  assign good_s  = ~err_slip_q & (err_abs <= ERR_W'(LOCK_TOL));

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    locked_d   = locked_q;
    if (err_valid_q) begin
      if (good_s) begin
        good_cnt_d = (good_cnt_q == GW'(LOCK_CNT)) ? good_cnt_q : good_cnt_q + GW'(1);
        bad_cnt_d  = '0;
      end else begin
        bad_cnt_d  = (bad_cnt_q == BW'(UNLOCK_CNT)) ? bad_cnt_q : bad_cnt_q + BW'(1);
        good_cnt_d = '0;
      end
      if (!locked_q && good_cnt_d == GW'(LOCK_CNT)) begin
        locked_d = 1'b1;
      end else if (locked_q && bad_cnt_d == BW'(UNLOCK_CNT)) begin
        locked_d   = 1'b0;
        good_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign phase_err  = phase_err_q;
  assign err_valid  = err_valid_q;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign locked     = locked_q;

endmodule
